// File: rtl/bcd_score_bank.sv
// bcd_score_bank: per-player packed-BCD score counters with shared session high score
module bcd_score_bank #(
   parameter int CHANNELS = 2,
   parameter int DIGITS   = 4,
   parameter int OWNER_W  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick,
   input  logic [CHANNELS-1:0]          crash,
   input  logic                         clr,
   output logic [CHANNELS*4*DIGITS-1:0] data,
   output logic [CHANNELS-1:0]          sat,
   output logic [4*DIGITS-1:0]          hi_score,
   output logic [OWNER_W-1:0]           hi_owner,
   output logic                         new_best
);
   localparam int SW = 4*DIGITS;
   localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

   logic [CHANNELS-1:0] crash_q;
   logic [SW-1:0]       best;
   logic [OWNER_W-1:0]  best_idx;
   logic                found;

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          cy;
      r  = v;
      cy = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = cy ? ((v[4*k +: 4] == 4'h9) ? 4'h0 : v[4*k +: 4] + 4'h1) : v[4*k +: 4];
         cy          = cy && (v[4*k +: 4] == 4'h9);
      end
      return r;
   endfunction

   // pick the largest rising-crash candidate that beats hi_score; strict compare keeps the lowest index on ties
   always_comb begin
      best     = hi_score;
      best_idx = hi_owner;
      found    = 1'b0;
      for (int c = 0; c < CHANNELS; c++)
         if (crash[c] && !crash_q[c] && data[c*SW +: SW] > best) begin
            best     = data[c*SW +: SW];
            best_idx = OWNER_W'(c);
            found    = 1'b1;
         end
   end

   // score counters, saturation flags and high-score capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data     <= '0;
         sat      <= '0;
         crash_q  <= '0;
         hi_score <= '0;
         hi_owner <= '0;
         new_best <= 1'b0;
      end else begin
         crash_q  <= crash;
         new_best <= found;
         if (found) begin
            hi_score <= best;
            hi_owner <= best_idx;
         end
         for (int c = 0; c < CHANNELS; c++)
            if (clr) begin
               data[c*SW +: SW] <= '0;
               sat[c]           <= 1'b0;
            end else if (tick && !crash[c] && !sat[c]) begin
               if (data[c*SW +: SW] == NINES)
                  sat[c] <= 1'b1;
               else
                  data[c*SW +: SW] <= bcd_inc(data[c*SW +: SW]);
            end
      end
   end
endmodule

// File: tb/tb_bcd_score_bank.sv
// tb_bcd_score_bank: random and directed stimulus against a decimal-integer score model
module tb_bcd_score_bank;
   localparam int CH = 2;
   localparam int DG = 4;
   localparam int OW = 3;
   localparam int SW = 4*DG;
   localparam int MAXV = 9999;

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic [CH-1:0] crash;
   logic          clr;
   logic [CH*SW-1:0] data;
   logic [CH-1:0] sat;
   logic [SW-1:0] hi_score;
   logic [OW-1:0] hi_owner;
   logic          new_best;

   int checks = 0;
   int errors = 0;

   int            m_score [CH] = '{default: 0};
   bit [CH-1:0]   m_sat = '0;
   bit [CH-1:0]   m_cq = '0;
   int            m_hi = 0;
   int            m_owner = 0;
   bit            m_nb = 1'b0;
   bit            cmp_en = 1'b0;

   bcd_score_bank #(.CHANNELS(CH), .DIGITS(DG), .OWNER_W(OW)) dut (
      .clk(clk), .rst(rst), .tick(tick), .crash(crash), .clr(clr),
      .data(data), .sat(sat), .hi_score(hi_score), .hi_owner(hi_owner), .new_best(new_best)
   );

   always #5 clk = ~clk;

   function automatic logic [SW-1:0] to_bcd(input int v);
      logic [SW-1:0] r;
      int            x;
      x = v;
      for (int k = 0; k < DG; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [CH*SW-1:0] model_data();
      logic [CH*SW-1:0] r;
      for (int c = 0; c < CH; c++) r[c*SW +: SW] = to_bcd(m_score[c]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic model_update();
      int bi;
      int bv;
      if (rst) begin
         for (int c = 0; c < CH; c++) m_score[c] = 0;
         m_sat = '0; m_cq = '0; m_hi = 0; m_owner = 0; m_nb = 1'b0;
      end else begin
         bi = -1;
         bv = m_hi;
         for (int c = 0; c < CH; c++)
            if (crash[c] && !m_cq[c] && m_score[c] > bv) begin
               bv = m_score[c];
               bi = c;
            end
         m_nb = (bi >= 0);
         if (bi >= 0) begin
            m_hi = bv;
            m_owner = bi;
         end
         for (int c = 0; c < CH; c++)
            if (clr) begin
               m_score[c] = 0;
               m_sat[c] = 1'b0;
            end else if (tick && !crash[c] && !m_sat[c]) begin
               if (m_score[c] == MAXV) m_sat[c] = 1'b1;
               else m_score[c] = m_score[c] + 1;
            end
         m_cq = crash;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_update();
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("data", 64'(data), 64'(model_data()));
         check("sat", 64'(sat), 64'(m_sat));
         check("hi_score", 64'(hi_score), 64'(to_bcd(m_hi)));
         check("hi_owner", 64'(hi_owner), 64'(m_owner));
         check("new_best", 64'(new_best), 64'(m_nb));
      end
   end

   task automatic step(input logic t, input logic [CH-1:0] cr, input logic c);
      tick = t; crash = cr; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n, input logic [CH-1:0] cr);
      repeat (n) step(1'b1, cr, 1'b0);
   endtask

   task automatic do_rst();
      tick = 1'b0; crash = '0; clr = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; crash = '0; clr = 1'b0;
      #12 rst = 1'b0;
      cmp_en = 1'b1;
      // reset mid-count, then count 10
      ticks(5, 2'b00);
      step(1'b0, 2'b01, 1'b0);
      check("pre_rst_hi", 64'(hi_score), 64'h0005);
      step(1'b0, 2'b00, 1'b0);
      ticks(3, 2'b00);
      rst = 1'b1;
      #1;
      check("rst_data", 64'(data), 64'h0);
      check("rst_sat", 64'(sat), 64'h0);
      check("rst_hi", 64'(hi_score), 64'h0);
      check("rst_nb", 64'(new_best), 64'h0);
      #1 rst = 1'b0;
      ticks(10, 2'b00);
      check("count10", 64'(data), 64'h0010_0010);
      // carry chain with channel 1 frozen
      do_rst();
      ticks(999, 2'b10);
      check("ch0_0999", 64'(data), 64'h0000_0999);
      step(1'b1, 2'b10, 1'b0);
      check("carry_1000", 64'(data), 64'h0000_1000);
      // saturation and clear
      ticks(8999, 2'b10);
      check("ch0_9999", 64'(data), 64'h0000_9999);
      check("sat_pre", 64'(sat), 64'h0);
      ticks(3, 2'b10);
      check("sat_hold", 64'(data), 64'h0000_9999);
      check("sat_set", 64'(sat), 64'h1);
      step(1'b0, 2'b10, 1'b1);
      check("clr_data", 64'(data), 64'h0);
      check("clr_sat", 64'(sat), 64'h0);
      // high score capture, equal no-update, greater update
      do_rst();
      ticks(123, 2'b00);
      step(1'b0, 2'b01, 1'b0);
      check("hs0_score", 64'(hi_score), 64'h0123);
      check("hs0_owner", 64'(hi_owner), 64'h0);
      check("hs0_nb", 64'(new_best), 64'h1);
      step(1'b0, 2'b01, 1'b0);
      check("hs0_nb_end", 64'(new_best), 64'h0);
      step(1'b0, 2'b11, 1'b0);
      check("eq_nb", 64'(new_best), 64'h0);
      check("eq_owner", 64'(hi_owner), 64'h0);
      step(1'b1, 2'b01, 1'b0);
      step(1'b0, 2'b11, 1'b0);
      check("hs1_score", 64'(hi_score), 64'h0124);
      check("hs1_owner", 64'(hi_owner), 64'h1);
      check("hs1_nb", 64'(new_best), 64'h1);
      // simultaneous crashes
      do_rst();
      ticks(50, 2'b00);
      step(1'b0, 2'b11, 1'b0);
      check("tie_owner", 64'(hi_owner), 64'h0);
      check("tie_score", 64'(hi_score), 64'h0050);
      check("tie_nb", 64'(new_best), 64'h1);
      step(1'b0, 2'b11, 1'b0);
      check("tie_nb_end", 64'(new_best), 64'h0);
      do_rst();
      ticks(40, 2'b00);
      step(1'b0, 2'b01, 1'b0);
      ticks(30, 2'b01);
      step(1'b0, 2'b00, 1'b0);
      check("pre_sim", 64'(data), 64'h0070_0040);
      step(1'b0, 2'b11, 1'b0);
      check("sim_owner", 64'(hi_owner), 64'h1);
      check("sim_score", 64'(hi_score), 64'h0070);
      // tick, clr and crash on the same edge
      do_rst();
      ticks(200, 2'b00);
      step(1'b1, 2'b01, 1'b1);
      check("same_hi", 64'(hi_score), 64'h0200);
      check("same_data", 64'(data), 64'h0);
      // randomized traffic
      do_rst();
      repeat (4000) begin
         logic [CH-1:0] cr;
         cr = ($urandom_range(0, 7) == 0) ? CH'($urandom) : crash;
         step($urandom_range(0, 3) != 0, cr, $urandom_range(0, 99) == 0);
         if ($urandom_range(0, 299) == 0) do_rst();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
